// File: rtl/product_accumulator.sv
// Accumulates N_TERMS unsigned products into a saturating sum. The result
// is held behind a valid/ready handshake until downstream consumes it.
module product_accumulator #(
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned ACC_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       prod,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [3:0]       NTerms  = 4'(N_TERMS);
  localparam logic [ACC_W-1:0] AccOnes = {ACC_W{1'b1}};

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]       count_q, count_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W:0]   prod_ext;
  logic [ACC_W:0]   sum;
  logic [3:0]       count_inc;
  logic             xfer;

  assign prod_ext  = (ACC_W + 1)'(prod);
  // One extra bit catches the carry that signals saturation.
  assign sum       = {1'b0, acc_q} + prod_ext;
  assign count_inc = count_q + 4'd1;

  // Handshake and output view; acc_out reads zero outside DONE.
  always_comb begin
    in_ready  = (state_q != StDone) && !clear;
    xfer      = in_valid && in_ready;
    out_valid = (state_q == StDone);
    acc_out   = (state_q == StDone) ? acc_q : '0;
    ovf       = ovf_q;
  end

  // Next-state, sum and term-count update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (clear) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end else if (xfer) begin
          acc_d   = prod_ext[ACC_W-1:0];
          count_d = 4'd1;
          ovf_d   = 1'b0;
          state_d = (NTerms == 4'd1) ? StDone : StAcc;
        end
      end
      StAcc: begin
        if (clear) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = StIdle;
        end else if (xfer) begin
          // Once saturated, acc stays all ones because sum can only grow.
          if (sum[ACC_W]) begin
            acc_d = AccOnes;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum[ACC_W-1:0];
          end
          count_d = count_inc;
          if (count_inc == NTerms) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        // clear is ignored here; only consumption or rst drops the result.
        if (out_ready) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        acc_d   = '0;
        count_d = '0;
        ovf_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level model that tracks the list of accepted terms.
module tb_product_accumulator;

  localparam int N_TERMS = 4;
  localparam int ACC_W   = 8;
  localparam int MAX_VAL = (1 << ACC_W) - 1;

  logic             clk;
  logic             rst;
  logic [6:0]       prod;
  logic             in_valid;
  logic             in_ready;
  logic             clear;
  logic [ACC_W-1:0] acc_out;
  logic             out_valid;
  logic             out_ready;
  logic             ovf;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: terms accepted so far in the current result, and whether held.
  int m_terms[$];
  bit m_done;

  product_accumulator #(
    .N_TERMS(N_TERMS),
    .ACC_W  (ACC_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .prod     (prod),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .clear    (clear),
    .acc_out  (acc_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_total();
    int s = 0;
    foreach (m_terms[i]) s += m_terms[i];
    return s;
  endfunction

  function automatic int m_result();
    int s = m_total();
    return (s > MAX_VAL) ? MAX_VAL : s;
  endfunction

  // One clock: drive inputs, check in_ready, advance model, check outputs.
  task automatic cycle(input bit v, input int p, input bit c, input bit o, input bit r);
    bit exp_ready;
    in_valid  = v;
    prod      = 7'(p);
    clear     = c;
    out_ready = o;
    rst       = r;
    #1;
    exp_ready = !m_done && !c;
    if (!r) check_eq("in_ready", int'(in_ready), int'(exp_ready));
    if (r) begin
      m_terms.delete();
      m_done = 1'b0;
    end else if (m_done) begin
      if (o) begin
        m_terms.delete();
        m_done = 1'b0;
      end
    end else if (c) begin
      m_terms.delete();
    end else if (v) begin
      m_terms.push_back(p);
      if (m_terms.size() == N_TERMS) m_done = 1'b1;
    end
    @(posedge clk);
    #1;
    check_eq("out_valid", int'(out_valid), int'(m_done));
    check_eq("acc_out", int'(acc_out), m_done ? m_result() : 0);
    check_eq("ovf", int'(ovf), (m_total() > MAX_VAL) ? 1 : 0);
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic consume();
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int beats[4];
    bit v;
    bit c;
    bit o;
    bit r;
    m_done    = 1'b0;
    in_valid  = 1'b0;
    prod      = '0;
    clear     = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;

    // Reset for two cycles then release.
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle_cycle();
    check_eq("rst_in_ready", int'(in_ready), 1);
    check_eq("rst_acc_out", int'(acc_out), 0);

    // Basic sum.
    beats = '{6, 35, 105, 0};
    foreach (beats[i]) cycle(1'b1, beats[i], 1'b0, 1'b0, 1'b0);
    check_eq("basic_valid", int'(out_valid), 1);
    check_eq("basic_sum", int'(acc_out), 146);
    check_eq("basic_ovf", int'(ovf), 0);
    consume();

    // Saturation.
    beats = '{105, 105, 105, 10};
    foreach (beats[i]) cycle(1'b1, beats[i], 1'b0, 1'b0, 1'b0);
    check_eq("sat_sum", int'(acc_out), 255);
    check_eq("sat_ovf", int'(ovf), 1);
    consume();
    check_eq("sat_ovf_cleared", int'(ovf), 0);

    // Backpressure in DONE, clear ignored while held.
    repeat (4) cycle(1'b1, 9, 1'b0, 1'b0, 1'b0);
    repeat (5) cycle(1'b1, 7, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 7, 1'b1, 1'b0, 1'b0);
    check_eq("bp_held", int'(acc_out), 36);
    cycle(1'b1, 7, 1'b0, 1'b1, 1'b0);
    check_eq("bp_idle", int'(out_valid), 0);
    repeat (4) cycle(1'b1, 7, 1'b0, 1'b0, 1'b0);
    check_eq("bp_sum", int'(acc_out), 28);
    consume();

    // Gaps and clear.
    cycle(1'b1, 50, 1'b0, 1'b0, 1'b0);
    idle_cycle();
    idle_cycle();
    cycle(1'b1, 60, 1'b0, 1'b0, 1'b0);
    idle_cycle();
    cycle(1'b1, 99, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) cycle(1'b1, i, 1'b0, 1'b0, 1'b0);
    check_eq("clear_sum", int'(acc_out), 10);
    consume();

    // Reset mid-ACC and in DONE with out_ready low.
    cycle(1'b1, 20, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 20, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 20, 1'b0, 1'b0, 1'b1);
    repeat (4) cycle(1'b1, 30, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
    check_eq("rst_done_valid", int'(out_valid), 0);
    repeat (4) cycle(1'b1, 20, 1'b0, 1'b0, 1'b0);
    check_eq("rst_sum", int'(acc_out), 80);
    consume();

    // Unreachable multiplier codes are summed unchanged.
    beats = '{127, 106, 0, 0};
    foreach (beats[i]) cycle(1'b1, beats[i], 1'b0, 1'b0, 1'b0);
    check_eq("high_codes", int'(acc_out), 233);
    consume();

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 15) == 0);
      o = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 99) == 0);
      cycle(v, int'($urandom_range(0, 127)), c, o, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
